// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with synchronizer, 3-sample glitch filter and mid-bit sampling
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       cclk,
  input  logic       clr,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic          sync1, sync2, hist1, hist2;
  logic          rx_f, rx_f_d;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    shift;

  // rx_f only moves when three consecutive synchronized samples agree
  always_ff @(posedge cclk) begin
    if (clr) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      hist1  <= 1'b1;
      hist2  <= 1'b1;
      rx_f   <= 1'b1;
      rx_f_d <= 1'b1;
    end else begin
      sync1  <= rx;
      sync2  <= sync1;
      hist1  <= sync2;
      hist2  <= hist1;
      if (sync2 == hist1 && hist1 == hist2)
        rx_f <= sync2;
      rx_f_d <= rx_f;
    end
  end

  always_ff @(posedge cclk) begin
    if (clr) begin
      state     <= IDLE;
      cnt       <= '0;
      bitn      <= 3'd0;
      shift     <= 8'h00;
      data      <= 8'h00;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_f_d && !rx_f) begin
            state <= START;
            cnt   <= HALF;
          end
        end
        START: begin
          if (cnt == '0) begin
            if (!rx_f) begin
              state <= DATA;
              cnt   <= FULL;
              bitn  <= 3'd0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DATA: begin
          if (cnt == '0) begin
            shift <= {rx_f, shift[7:1]};
            cnt   <= FULL;
            bitn  <= bitn + 3'd1;
            if (bitn == 3'd7)
              state <= STOP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          if (cnt == '0) begin
            if (rx_f) begin
              data    <= shift;
              rx_done <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed scoreboard bench for uart_rx at CLKS_PER_BIT = 16
module tb_uart_rx;

  localparam int CPB = 16;

  typedef struct packed {
    logic       err;
    logic [7:0] d;
  } exp_t;

  logic       cclk;
  logic       clr;
  logic       rx;
  logic [7:0] data;
  logic       rx_done;
  logic       frame_err;
  logic       busy;

  exp_t       sb[$];
  int         nvec = 0;
  int         nerr = 0;
  int         cyc = 0;
  int         n_done = 0;
  int         n_ferr = 0;
  int         done_cyc = -1;
  int         rise_cyc = -1;
  int         fall_cyc = -1;
  logic       busy_q = 1'b0;
  logic       busy_seen = 1'b0;
  logic [7:0] last_good = 8'h00;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .cclk      (cclk),
    .clr       (clr),
    .rx        (rx),
    .data      (data),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial cclk = 1'b0;
  always #5 cclk = ~cclk;

  always @(posedge cclk) cyc <= cyc + 1;

  // scoreboard consumer: every pulse must match the oldest pending expectation
  always @(negedge cclk) begin
    exp_t e;
    if (busy && !busy_q) rise_cyc = cyc;
    if (!busy && busy_q) fall_cyc = cyc;
    if (busy) busy_seen = 1'b1;
    busy_q = busy;
    if (rx_done || frame_err) begin
      if (rx_done) begin n_done++; done_cyc = cyc; end
      if (frame_err) n_ferr++;
      nvec++;
      assert (!(rx_done && frame_err)) else begin
        nerr++; $error("FAIL pulse_overlap: observed rx_done=%b frame_err=%b expected one", rx_done, frame_err);
      end
      nvec++;
      assert (sb.size() > 0) else begin
        nerr++; $error("FAIL unexpected_pulse: observed rx_done=%b frame_err=%b expected none", rx_done, frame_err);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        nvec++;
        assert (frame_err === e.err) else begin
          nerr++; $error("FAIL pulse_kind: observed frame_err=%b expected %b", frame_err, e.err);
        end
        nvec++;
        assert (data === e.d) else begin
          nerr++; $error("FAIL sb_data: observed %h expected %h", data, e.d);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++; $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bits(input logic v, input int n);
    rx = v;
    repeat (n) begin @(posedge cclk); #1; end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    exp_t e;
    e.err = !stop;
    e.d   = stop ? b : last_good;
    sb.push_back(e);
    if (stop) last_good = b;
    drive_bits(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bits(b[i], CPB);
    drive_bits(stop, CPB);
  endtask

  task automatic send_glitchy(input logic [7:0] b);
    logic [9:0] bits;
    exp_t e;
    e.err = 1'b0;
    e.d   = b;
    sb.push_back(e);
    last_good = b;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++)
      for (int k = 0; k < CPB; k++) begin
        rx = (k == 5 || k == 11) ? ~bits[i] : bits[i];
        @(posedge cclk); #1;
      end
    rx = 1'b1;
  endtask

  initial begin
    int c, d0, e0;
    clr = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge cclk);
    #1;
    clr = 1'b0;
    chk("reset_data", data, 8'h00);
    chk("reset_done", rx_done, 1'b0);
    chk("reset_ferr", frame_err, 1'b0);
    chk("reset_busy", busy, 1'b0);
    drive_bits(1'b1, 20);

    // good frame with exact pulse and busy timing
    c = cyc;
    send_frame(8'hA5, 1'b1);
    drive_bits(1'b1, 10);
    chk("a5_data", data, 8'hA5);
    chk("a5_done_cyc", done_cyc, c + 5 + CPB / 2 + 9 * CPB + 1);
    chk("a5_busy_rise", rise_cyc, c + 6);
    chk("a5_busy_fall", fall_cyc, c + 5 + CPB / 2 + 9 * CPB + 1);
    chk("a5_ferr_cnt", n_ferr, 0);

    // bad stop bit followed by a long break
    d0 = n_done; e0 = n_ferr;
    send_frame(8'h3C, 1'b0);
    drive_bits(1'b0, 200);
    chk("break_ferr_cnt", n_ferr, e0 + 1);
    chk("break_done_cnt", n_done, d0);
    chk("break_data", data, 8'hA5);
    chk("break_busy", busy, 1'b0);
    drive_bits(1'b1, 20);
    chk("break_release_busy", busy, 1'b0);

    // false start and short glitch
    d0 = n_done; e0 = n_ferr;
    busy_seen = 1'b0;
    drive_bits(1'b0, 6);
    drive_bits(1'b1, 30);
    chk("false_start_busy_seen", busy_seen, 1'b1);
    chk("false_start_busy", busy, 1'b0);
    chk("false_start_pulses", n_done + n_ferr, d0 + e0);
    chk("false_start_data", data, 8'hA5);
    busy_seen = 1'b0;
    drive_bits(1'b0, 2);
    drive_bits(1'b1, 30);
    chk("glitch_busy_seen", busy_seen, 1'b0);

    // back-to-back frames, no idle gap
    d0 = n_done;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h81, 1'b1);
    drive_bits(1'b1, 20);
    chk("b2b_done_cnt", n_done, d0 + 3);
    chk("b2b_data", data, 8'h81);

    // reset in the middle of data bit 4
    d0 = n_done; e0 = n_ferr;
    drive_bits(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bits(i[0] ? 1'b0 : 1'b1, CPB);
    drive_bits(1'b1, CPB / 2);
    clr = 1'b1;
    @(posedge cclk); #1;
    clr = 1'b0;
    chk("midreset_busy", busy, 1'b0);
    chk("midreset_data", data, 8'h00);
    last_good = 8'h00;
    drive_bits(1'b1, 30);
    chk("midreset_pulses", n_done + n_ferr, d0 + e0);
    send_frame(8'h12, 1'b1);
    drive_bits(1'b1, 10);
    chk("after_reset_data", data, 8'h12);

    // single-cycle glitches inside each bit
    d0 = n_done;
    send_glitchy(8'h6B);
    drive_bits(1'b1, 10);
    chk("glitchy_done_cnt", n_done, d0 + 1);
    chk("glitchy_data", data, 8'h6B);

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
